// File: rtl/wr_decoder_pkg.sv
// Shared types and default sizing for the two-port write decoder.
package wr_decoder_pkg;

    localparam int unsigned SEL_W_DEF = 5;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational select+enable to one-hot decoder, one instance per write port.
module onehot_dec #(
    parameter int unsigned SEL_W = 5
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   oh_c
);

    always_comb begin
        oh_c = '0;
        if (en) begin
            oh_c[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/wr_decoder_2p.sv
// Two-port register write decoder: port 0 always wins, a colliding port 1 write is parked and replayed.
// Optional build macro ZERO_REG_PROTECT_EN drops every write to index 0.
module wr_decoder_2p
    import wr_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we0,
    input  logic [SEL_W-1:0]        sel0,
    input  logic                    we1,
    input  logic [SEL_W-1:0]        sel1,
    output logic                    ready1,
    output logic [(2**SEL_W)-1:0]   wen,
    output logic [CNT_W-1:0]        coll_cnt
);

    localparam int unsigned NREG = 2**SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   hold_idx;
    logic [SEL_W-1:0]   hold_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [NREG-1:0]    oh0_c;
    logic [NREG-1:0]    oh1_c;
    logic [SEL_W-1:0]   sel1_mux_c;
    logic               en1_c;
    logic               bump_c;
    logic               v0_c;
    logic               v1_c;

`ifdef ZERO_REG_PROTECT_EN
    assign v0_c = we0 && (sel0 != '0);
    assign v1_c = we1 && (sel1 != '0);
`else
    assign v0_c = we0;
    assign v1_c = we1;
`endif

    assign ready1 = (state == PASS);

    onehot_dec #(.SEL_W(SEL_W)) u_dec0 (
        .en   (v0_c),
        .sel  (sel0),
        .oh_c (oh0_c)
    );

    // Port 1 decoder serves either the live request or the parked index.
    onehot_dec #(.SEL_W(SEL_W)) u_dec1 (
        .en   (en1_c),
        .sel  (sel1_mux_c),
        .oh_c (oh1_c)
    );

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_idx;
        cnt_nxt    = coll_cnt;
        sel1_mux_c = sel1;
        en1_c      = 1'b0;
        bump_c     = 1'b0;
        case (state)
            PASS: begin
                if (v1_c && v0_c && (sel0 == sel1)) begin
                    hold_nxt  = sel1;
                    bump_c    = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    en1_c = v1_c;
                end
            end
            HOLD: begin
                sel1_mux_c = hold_idx;
                if (v0_c && (sel0 == hold_idx)) begin
                    bump_c = 1'b1;
                end else begin
                    en1_c     = 1'b1;
                    state_nxt = PASS;
                end
            end
            default: state_nxt = PASS;
        endcase
        if (bump_c && (coll_cnt != CNT_MAX)) begin
            cnt_nxt = coll_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= PASS;
            hold_idx <= '0;
            wen      <= '0;
            coll_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_idx <= hold_nxt;
            wen      <= oh0_c | oh1_c;
            coll_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wr_decoder_2p.sv
// Self-checking bench for wr_decoder_2p: directed table, corner sequences, randomized model compare.
module tb_wr_decoder_2p;

    logic        clock = 1'b0;
    logic        reset, we0, we1;
    logic [4:0]  sel0, sel1;
    logic        ready1;
    logic [31:0] wen;
    logic [7:0]  coll_cnt;

    logic        reset_b, we0_b, we1_b;
    logic [4:0]  sel0_b, sel1_b;
    logic        ready1_b;
    logic [31:0] wen_b;
    logic [1:0]  coll_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int m_pend;
    int m_cnt;

    always #5 clock = ~clock;

    wr_decoder_2p dut (
        .clock(clock), .reset(reset), .we0(we0), .sel0(sel0), .we1(we1), .sel1(sel1),
        .ready1(ready1), .wen(wen), .coll_cnt(coll_cnt)
    );

    wr_decoder_2p #(.SEL_W(5), .CNT_W(2)) dut_small (
        .clock(clock), .reset(reset_b), .we0(we0_b), .sel0(sel0_b), .we1(we1_b), .sel1(sel1_b),
        .ready1(ready1_b), .wen(wen_b), .coll_cnt(coll_cnt_b)
    );

    typedef struct {
        logic        rst;
        logic        w0;
        logic [4:0]  s0;
        logic        w1;
        logic [4:0]  s1;
        logic [31:0] ewen;
        logic        erdy;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] bit_of(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    function automatic vec_t mk(input logic r, input logic a, input int sa, input logic b, input int sb,
                                input logic [31:0] ew, input logic er, input int ec);
        vec_t v;
        v.rst = r; v.w0 = a; v.s0 = 5'(sa); v.w1 = b; v.s1 = 5'(sb);
        v.ewen = ew; v.erdy = er; v.ecnt = 8'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic bit idx_ok(input int i);
`ifdef ZERO_REG_PROTECT_EN
        return i != 0;
`else
        return 1'b1;
`endif
    endfunction

    // Reference: port 0 always lands; a same-index port 1 write is deferred until port 0 leaves that index.
    task automatic model(input logic r, input logic a, input int sa, input logic b, input int sb,
                         output logic [31:0] ew, output logic er, output int ec);
        bit v0;
        ew = '0;
        if (r) begin
            m_pend = -1;
            m_cnt  = 0;
        end else begin
            v0 = a && idx_ok(sa);
            if (v0) ew = ew | bit_of(sa);
            if (m_pend >= 0) begin
                if (v0 && sa == m_pend) begin
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    ew = ew | bit_of(m_pend);
                    m_pend = -1;
                end
            end else if (b && idx_ok(sb)) begin
                if (v0 && sa == sb) begin
                    m_pend = sb;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    ew = ew | bit_of(sb);
                end
            end
        end
        er = (m_pend < 0);
        ec = m_cnt;
    endtask

    initial begin
        logic [31:0] ew;
        logic        er;
        int          ec;
        logic        r, a, b;
        int          sa, sb;

        reset = 1'b1; we0 = 1'b0; we1 = 1'b0; sel0 = '0; sel1 = '0;
        reset_b = 1'b1; we0_b = 1'b0; we1_b = 1'b0; sel0_b = '0; sel1_b = '0;

        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 3, 1, 17, bit_of(3) | bit_of(17), 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 9, 1, 9, bit_of(9), 0, 1));
        tbl.push_back(mk(0, 0, 9, 0, 0, bit_of(9), 1, 1));
        tbl.push_back(mk(0, 1, 9, 1, 9, bit_of(9), 0, 2));
        tbl.push_back(mk(0, 1, 9, 0, 0, bit_of(9), 0, 3));
        tbl.push_back(mk(0, 1, 9, 0, 0, bit_of(9), 0, 4));
        tbl.push_back(mk(0, 1, 9, 0, 0, bit_of(9), 0, 5));
        tbl.push_back(mk(0, 1, 4, 1, 9, bit_of(4) | bit_of(9), 1, 5));
        tbl.push_back(mk(0, 1, 5, 1, 5, bit_of(5), 0, 6));
        tbl.push_back(mk(1, 1, 7, 1, 8, 32'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 20, bit_of(20), 1, 0));
        tbl.push_back(mk(0, 1, 31, 0, 0, bit_of(31), 1, 0));
        tbl.push_back(mk(0, 1, 2, 1, 2, bit_of(2), 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 6, bit_of(2), 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 1));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; we0 = tbl[i].w0; sel0 = tbl[i].s0; we1 = tbl[i].w1; sel1 = tbl[i].s1;
            cyc();
            chk($sformatf("tbl%0d wen", i), wen, tbl[i].ewen);
            chk($sformatf("tbl%0d ready1", i), 32'(ready1), 32'(tbl[i].erdy));
            chk($sformatf("tbl%0d coll_cnt", i), 32'(coll_cnt), 32'(tbl[i].ecnt));
        end

        // Index 0 collision: dropped when protected, arbitrated normally otherwise.
        reset = 1'b1; we0 = 1'b0; we1 = 1'b0;
        cyc();
        reset = 1'b0; we0 = 1'b1; sel0 = 5'd0; we1 = 1'b1; sel1 = 5'd0;
        cyc();
        we0 = 1'b0; we1 = 1'b0;
`ifdef ZERO_REG_PROTECT_EN
        chk("zero c1 wen", wen, 32'h0);
        chk("zero c1 ready1", 32'(ready1), 32'd1);
        chk("zero c1 coll_cnt", 32'(coll_cnt), 32'd0);
        cyc();
        chk("zero c2 wen", wen, 32'h0);
        chk("zero c2 ready1", 32'(ready1), 32'd1);
`else
        chk("zero c1 wen", wen, 32'h1);
        chk("zero c1 ready1", 32'(ready1), 32'd0);
        chk("zero c1 coll_cnt", 32'(coll_cnt), 32'd1);
        cyc();
        chk("zero c2 wen", wen, 32'h1);
        chk("zero c2 ready1", 32'(ready1), 32'd1);
`endif

        // Saturation with a 2-bit counter.
        cyc();
        reset_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            we0_b = 1'b1; we1_b = 1'b1; sel0_b = 5'(k); sel1_b = 5'(k);
            cyc();
            chk($sformatf("sat k%0d coll_cnt", k), 32'(coll_cnt_b), (k > 3) ? 32'd3 : 32'(k));
            we0_b = 1'b0; we1_b = 1'b0;
            cyc();
            chk($sformatf("sat k%0d replay", k), wen_b, bit_of(k));
        end

        // Randomized run against the reference model.
        m_pend = -1;
        m_cnt  = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = (i == 0) || ($urandom_range(0, 199) == 0);
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            sb = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) sb = sa;
            reset = r; we0 = a; sel0 = 5'(sa); we1 = b; sel1 = 5'(sb);
            cyc();
            model(r, a, sa, b, sb, ew, er, ec);
            chk($sformatf("rnd%0d wen", i), wen, ew);
            chk($sformatf("rnd%0d ready1", i), 32'(ready1), 32'(er));
            chk($sformatf("rnd%0d coll_cnt", i), 32'(coll_cnt), 32'(ec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
